// File: rtl/seq_restoring_divider_if.sv
// Request/response bundle for the sequential restoring divider.
// master = requester/consumer side, slave = divider side.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one trial subtraction per clock, MSB first.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude core + sign fix-up).
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] num, den, rem, quo;
  logic [CW-1:0]    cnt;
  logic             fin;
  logic [WIDTH-1:0] res_q, res_r;
  logic             res_z;
  logic             accept, release_hs;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

  assign accept     = bus.in_valid && bus.in_ready;
  assign release_hs = bus.out_valid && bus.out_ready;
  assign shifted    = {rem, num[cnt]};
  assign trial      = shifted - {1'b0, den};

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  assign a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign b_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  // Remainder follows the dividend sign, so truncation is toward zero.
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && accept) begin
      neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      neg_r <= bus.dividend[WIDTH-1];
    end
  end
`else
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
  assign q_fix = quo;
  assign r_fix = rem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bus.divisor == '0) ? DONE : CALC;
      CALC:    if (fin) state_nxt = DONE;
      DONE:    if (release_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  assign bus.quotient    = res_q;
  assign bus.remainder   = res_r;
  assign bus.div_by_zero = res_z;

  // fin marks the extra edge that loads (and sign-fixes) the result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num   <= '0;
      den   <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      fin   <= 1'b0;
      res_q <= '0;
      res_r <= '0;
      res_z <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (bus.divisor == '0) begin
            res_q <= '1;
            res_r <= bus.dividend;
            res_z <= 1'b1;
          end else begin
            num <= a_mag;
            den <= b_mag;
            rem <= '0;
            cnt <= CW'(WIDTH-1);
            fin <= 1'b0;
          end
        end
        CALC: begin
          if (fin) begin
            res_q <= q_fix;
            res_r <= r_fix;
            res_z <= 1'b0;
          end else begin
            rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
            if (cnt == '0) fin <= 1'b1;
            else           cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
